// File: rtl/comnet_bridge.sv
// Serial command-network slave on the system clock: decodes START/addr/RW/data/STOP
// frames from oversampled SCl/SDa and runs one TBC bus op at a time with a timeout.
module comnet_bridge #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int FRAME_AW    = 8,
    parameter logic [ADDR_W-FRAME_AW-1:0] BASE_ADDR = 'h90,
    parameter int TURN_BITS   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SDa,
    input  logic              SCl,
    output logic              RDa,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] rdata,
    output logic              wr,
    output logic              rd,
    input  logic              ack,
    input  logic              nack,
    input  logic              unknown,
    output logic              timeout,
    output logic              frame_err,
    output logic [1:0]        stat,
    output logic              busy
);
    localparam int MAXB  = (DATA_W > FRAME_AW ? DATA_W : FRAME_AW) > TURN_BITS ?
                           (DATA_W > FRAME_AW ? DATA_W : FRAME_AW) : TURN_BITS;
    localparam int CNT_W = $clog2(MAXB + 1);
    localparam int TO_W  = TIMEOUT_CYC >= 512 ? $clog2(TIMEOUT_CYC + 1) : 9;

    typedef enum logic [2:0] {IDLE, ADDR, RW, TURN, RDATA, RSTAT, WDATA, WSTOP} fstate_t;
    typedef enum logic {BIDLE, BWAIT} bstate_t;

    fstate_t             fs;
    bstate_t             bs;
    logic [1:0]          scl_sy, sda_sy;
    logic                scl_h, sda_h;
    logic [CNT_W-1:0]    cnt;
    logic [FRAME_AW-1:0] ash;
    logic [DATA_W-1:0]   wsh, shreg;
    logic                req_pend, req_rd, late;
    logic [TO_W-1:0]     tcnt;

    // idle line is high, so synchronisers reset to 1 to avoid phantom edges
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sy <= 2'b11;
            sda_sy <= 2'b11;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_sy <= {scl_sy[0], SCl};
            sda_sy <= {sda_sy[0], SDa};
            scl_h  <= scl_sy[1];
            sda_h  <= sda_sy[1];
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_c, stop_c, bus_acc, bus_busy, late_now;
    assign scl      = scl_sy[1];
    assign sda      = sda_sy[1];
    assign scl_rise = scl & ~scl_h;
    assign scl_fall = ~scl & scl_h;
    assign start_c  = scl & scl_h & ~sda & sda_h;
    assign stop_c   = scl & scl_h & sda & ~sda_h;
    assign bus_acc  = (bs == BIDLE) && req_pend;
    assign bus_busy = (bs != BIDLE) || req_pend;
    // lateness is decided once, at the first data fall of a read
    assign late_now = (cnt == '0) ? bus_busy : late;
    assign busy     = (fs != IDLE) || bus_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs        <= IDLE;
            cnt       <= '0;
            ash       <= '0;
            wsh       <= '0;
            addr      <= '0;
            data      <= '0;
            req_pend  <= 1'b0;
            req_rd    <= 1'b0;
            late      <= 1'b0;
            RDa       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (bus_acc) req_pend <= 1'b0;
            if (start_c) begin
                if (fs != IDLE && fs != WSTOP) frame_err <= 1'b1;
                fs  <= ADDR;
                cnt <= '0;
                RDa <= 1'b0;
            end else if (stop_c) begin
                if (fs != IDLE && fs != WSTOP) frame_err <= 1'b1;
                fs  <= IDLE;
                RDa <= 1'b0;
            end else begin
                case (fs)
                    ADDR: if (scl_rise) begin
                        ash <= {ash[FRAME_AW-2:0], sda};
                        if (cnt == CNT_W'(FRAME_AW - 1)) begin
                            fs  <= RW;
                            cnt <= '0;
                        end else cnt <= cnt + 1'b1;
                    end
                    RW: if (scl_rise) begin
                        addr <= {BASE_ADDR, ash};
                        cnt  <= '0;
                        if (sda) begin
                            req_pend <= 1'b1;
                            req_rd   <= 1'b1;
                            fs       <= TURN;
                        end else fs <= WDATA;
                    end
                    TURN: begin
                        RDa <= 1'b0;
                        if (scl_rise) begin
                            if (cnt == CNT_W'(TURN_BITS - 1)) begin
                                fs  <= RDATA;
                                cnt <= '0;
                            end else cnt <= cnt + 1'b1;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (cnt == '0) late <= bus_busy;
                            RDa <= shreg[DATA_W-1] & ~late_now;
                        end
                        if (scl_rise) begin
                            if (cnt == CNT_W'(DATA_W - 1)) begin
                                fs  <= RSTAT;
                                cnt <= '0;
                            end else cnt <= cnt + 1'b1;
                        end
                    end
                    RSTAT: begin
                        if (scl_fall) RDa <= ~late & ((cnt == '0) ? stat[1] : stat[0]);
                        if (scl_rise) begin
                            if (cnt == CNT_W'(1)) begin
                                fs  <= WSTOP;
                                cnt <= '0;
                            end else cnt <= cnt + 1'b1;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        wsh <= {wsh[DATA_W-2:0], sda};
                        if (cnt == CNT_W'(DATA_W - 1)) begin
                            data     <= {wsh[DATA_W-2:0], sda};
                            req_pend <= 1'b1;
                            req_rd   <= 1'b0;
                            fs       <= WSTOP;
                            cnt      <= '0;
                        end else cnt <= cnt + 1'b1;
                    end
                    WSTOP: RDa <= 1'b0;
                    default: RDa <= 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bs      <= BIDLE;
            wr      <= 1'b0;
            rd      <= 1'b0;
            tcnt    <= '0;
            stat    <= 2'b00;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (bs)
                BIDLE: if (req_pend) begin
                    bs   <= BWAIT;
                    tcnt <= '0;
                    rd   <= req_rd;
                    wr   <= ~req_rd;
                end
                BWAIT: begin
                    if (ack || nack || unknown) begin
                        rd   <= 1'b0;
                        wr   <= 1'b0;
                        bs   <= BIDLE;
                        stat <= ack ? 2'b01 : nack ? 2'b10 : 2'b11;
                    end else if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        rd      <= 1'b0;
                        wr      <= 1'b0;
                        bs      <= BIDLE;
                        stat    <= 2'b00;
                        timeout <= 1'b1;
                    end else tcnt <= tcnt + 1'b1;
                end
                default: bs <= BIDLE;
            endcase
        end
    end

    // read-data shifter: loaded by the bus side on ack, drained by the frame side
    always_ff @(posedge clk) begin
        if (reset) shreg <= '0;
        else if (bs == BWAIT && ack && rd) shreg <= rdata;
        else if (fs == RDATA && scl_fall) shreg <= {shreg[DATA_W-2:0], 1'b0};
    end
endmodule
